// File: rtl/mem_arbiter.sv
// Two-port to one-port cacheline memory arbiter: one transaction outstanding at a time.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise data has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_read,
    input  logic              inst_write,
    input  logic [ADDR_W-1:0] inst_address,
    input  logic [LINE_W-1:0] inst_wdata,
    output logic [LINE_W-1:0] inst_rdata,
    output logic              inst_resp,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [LINE_W-1:0] data_wdata,
    output logic [LINE_W-1:0] data_rdata,
    output logic              data_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;

    state_t state, state_nxt;
    logic   inst_pend, data_pend, pick_data;

    assign inst_pend  = inst_read | inst_write;
    assign data_pend  = data_read | data_write;
    assign inst_rdata = pmem_rdata;
    assign data_rdata = pmem_rdata;

`ifdef MEM_ARB_RR_EN
    // 1 = data was granted last; reset value favours data on the first tie
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b0;
        else if (state == IDLE && state_nxt != IDLE)
            last_grant <= (state_nxt == SERVE_D);
    end

    assign pick_data = ~last_grant;
`else
    assign pick_data = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        inst_resp    = 1'b0;
        data_resp    = 1'b0;
        case (state)
            IDLE: begin
                if (inst_pend && data_pend)
                    state_nxt = pick_data ? SERVE_D : SERVE_I;
                else if (inst_pend)
                    state_nxt = SERVE_I;
                else if (data_pend)
                    state_nxt = SERVE_D;
            end
            SERVE_I: begin
                // write wins when a requester asserts both
                pmem_read    = inst_read & ~inst_write;
                pmem_write   = inst_write;
                pmem_address = inst_address;
                pmem_wdata   = inst_wdata;
                inst_resp    = pmem_resp;
                if (pmem_resp)
                    state_nxt = IDLE;
            end
            SERVE_D: begin
                pmem_read    = data_read & ~data_write;
                pmem_write   = data_write;
                pmem_address = data_address;
                pmem_wdata   = data_wdata;
                data_resp    = pmem_resp;
                if (pmem_resp)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, then randomized traffic against a transaction-level owner model.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          inst_read, inst_write, data_read, data_write;
    logic [AW-1:0] inst_address, data_address;
    logic [LW-1:0] inst_wdata, data_wdata, inst_rdata, data_rdata;
    logic          inst_resp, data_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .inst_read(inst_read), .inst_write(inst_write), .inst_address(inst_address),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_resp(inst_resp),
        .data_read(data_read), .data_write(data_write), .data_address(data_address),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_resp(data_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: who owns memory this cycle (0 none, 1 inst, 2 data), and who won last
    int owner = 0;
    bit last_d = 1'b0;

    // randomized requester / memory state
    logic          act[2];
    logic [1:0]    rw[2];
    logic [AW-1:0] adr[2];
    logic [LW-1:0] wd[2];
    logic          resp_seen[2];
    int            mem_busy = 0;
    int            lat = 2;
    bit            prev_req = 1'b0;
    bit            grants[$];

    task automatic chk(input string name, input logic [LW-1:0] act_v, input logic [LW-1:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    // compare DUT outputs with what the owner model says they must be
    task automatic sense();
        logic          er, ew;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewd;
        #1;
        er = 1'b0; ew = 1'b0; ea = '0; ewd = '0;
        if (owner == 1) begin
            ew = inst_write; er = inst_read && !inst_write; ea = inst_address; ewd = inst_wdata;
        end else if (owner == 2) begin
            ew = data_write; er = data_read && !data_write; ea = data_address; ewd = data_wdata;
        end
        chk("pmem_read", pmem_read, er);
        chk("pmem_write", pmem_write, ew);
        chk("pmem_address", pmem_address, ea);
        chk("pmem_wdata", pmem_wdata, ewd);
        chk("inst_resp", inst_resp, owner == 1 && pmem_resp);
        chk("data_resp", data_resp, owner == 2 && pmem_resp);
        chk("inst_rdata", inst_rdata, pmem_rdata);
        chk("data_rdata", data_rdata, pmem_rdata);
    endtask

    task automatic adv();
        bit ip, dp;
        resp_seen[0] = inst_resp;
        resp_seen[1] = data_resp;
        if (rst || pmem_resp) mem_busy = 0;
        else if (pmem_read || pmem_write) mem_busy++;
        else mem_busy = 0;
        if ((pmem_read || pmem_write) && !prev_req) grants.push_back(pmem_address[AW-1]);
        prev_req = pmem_read || pmem_write;
        ip = inst_read || inst_write;
        dp = data_read || data_write;
        if (rst) begin
            owner = 0; last_d = 1'b0;
        end else if (owner != 0) begin
            if (pmem_resp) owner = 0;
        end else begin
            if (ip && dp) begin
`ifdef MEM_ARB_RR_EN
                owner = last_d ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (ip) owner = 1;
            else if (dp) owner = 2;
            if (owner != 0) last_d = (owner == 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_line(output logic [LW-1:0] v);
        for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom();
    endtask

    // requesters obey the hold-until-resp / drop-next-cycle contract; memory answers after lat cycles
    task automatic drive(input int p_req, input int p_rst, input bit fixed);
        logic [31:0] t;
        rst = ($urandom_range(0, 99) < p_rst);
        for (int s = 0; s < 2; s++) begin
            if (act[s] && resp_seen[s]) begin
                act[s] = 1'b0;
            end else if (!act[s] && $urandom_range(0, 99) < p_req) begin
                act[s] = 1'b1;
                rw[s] = 2'($urandom_range(1, 3));
                t = $urandom();
                adr[s] = {(s == 1) ? 1'b1 : 1'b0, t[30:0]};
                rand_line(wd[s]);
            end
            resp_seen[s] = 1'b0;
        end
        inst_read = act[0] & rw[0][0]; inst_write = act[0] & rw[0][1];
        inst_address = adr[0]; inst_wdata = wd[0];
        data_read = act[1] & rw[1][0]; data_write = act[1] & rw[1][1];
        data_address = adr[1]; data_wdata = wd[1];
        rand_line(pmem_rdata);
        if (mem_busy > 0 && mem_busy >= lat) begin
            pmem_resp = 1'b1;
            lat = fixed ? 2 : $urandom_range(1, 4);
        end else if (mem_busy == 0 && owner == 0 && $urandom_range(0, 9) == 0) begin
            pmem_resp = 1'b1;
        end else begin
            pmem_resp = 1'b0;
        end
    endtask

    task automatic clear_inputs();
        inst_read = 0; inst_write = 0; data_read = 0; data_write = 0;
        pmem_resp = 0; pmem_rdata = '0;
        for (int s = 0; s < 2; s++) begin
            act[s] = 0; resp_seen[s] = 0; rw[s] = 0; adr[s] = '0; wd[s] = '0;
        end
    endtask

    initial begin
        int n;
        clear_inputs();
        inst_address = '0; inst_wdata = '0; data_address = '0; data_wdata = '0;
        // reset with a live inst request, then a single inst read
        rst = 1; inst_read = 1; inst_address = 32'h0000_0060;
        @(posedge clk);
        #1;
        owner = 0;
        repeat (2) begin
            sense();
            chk("rst_pmem_read", pmem_read, 1'b0);
            chk("rst_inst_resp", inst_resp, 1'b0);
            adv();
        end
        rst = 0;
        sense(); chk("post_rst_idle", pmem_read, 1'b0); adv();
        sense(); chk("post_rst_read", pmem_read, 1'b1); chk("inst_addr", pmem_address, 32'h60); adv();
        repeat (2) begin sense(); chk("inst_wait_resp", inst_resp, 1'b0); adv(); end
        pmem_resp = 1; pmem_rdata = {32{8'hA5}};
        sense();
        chk("inst_resp_pulse", inst_resp, 1'b1);
        chk("inst_rdata_a5", inst_rdata, {32{8'hA5}});
        chk("inst_no_data_resp", data_resp, 1'b0);
        adv();
        inst_read = 0; pmem_resp = 0;
        sense(); chk("inst_resp_one_cycle", inst_resp, 1'b0); chk("turn_idle", pmem_read, 1'b0); adv();

        // data write
        data_write = 1; data_address = 32'h1000; data_wdata = {8{32'hDEADBEEF}};
        sense(); adv();
        sense();
        chk("dw_write", pmem_write, 1'b1);
        chk("dw_read", pmem_read, 1'b0);
        chk("dw_addr", pmem_address, 32'h1000);
        chk("dw_wdata", pmem_wdata, {8{32'hDEADBEEF}});
        adv();
        pmem_resp = 1;
        sense(); chk("dw_data_resp", data_resp, 1'b1); chk("dw_inst_resp", inst_resp, 1'b0); adv();
        data_write = 0; pmem_resp = 0;
        sense(); adv();

        // reset in the second SERVE_I cycle, memory answers a cycle later
        inst_read = 1; inst_address = 32'h80;
        sense(); adv();
        sense(); chk("mid_serve", pmem_read, 1'b1); adv();
        rst = 1;
        sense(); adv();
        rst = 0; pmem_resp = 1;
        sense(); chk("mid_no_resp", inst_resp, 1'b0); chk("mid_idle", pmem_read, 1'b0); adv();
        pmem_resp = 0;
        sense(); chk("mid_regrant", pmem_read, 1'b1); chk("mid_regrant_addr", pmem_address, 32'h80); adv();
        pmem_resp = 1;
        sense(); chk("mid_resp", inst_resp, 1'b1); adv();
        clear_inputs();
        sense(); adv();

        // continuous contention from reset: expected D,I,D,I
        rst = 1;
        sense(); adv();
        rst = 0;
        grants.delete();
        mem_busy = 0; prev_req = 0; lat = 2;
        n = 0;
        while (grants.size() < 4 && n < 80) begin
            drive(100, 0, 1'b1);
            sense(); adv();
            n++;
        end
        chk("contention_bound", grants.size() >= 4, 1'b1);
        if (grants.size() >= 4) begin
            chk("grant0_d", grants[0], 1'b1);
            chk("grant1_i", grants[1], 1'b0);
            chk("grant2_d", grants[2], 1'b1);
            chk("grant3_i", grants[3], 1'b0);
        end

        // randomized traffic with stray responses and occasional resets
        for (int c = 0; c < 3000; c++) begin
            drive(40, 2, 1'b0);
            sense(); adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter placed directly downstream of the `cpu` top level. It merges the instruction-side and data-side cacheline requests onto the single physical memory port. It serializes them under a fixed or round-robin priority and routes each response back to the requester that owns it. One transaction is outstanding at a time, so neither pipeline port sees another port's response.

## Interface
Parameters:
- `ADDR_W`, 32, address width of all ports.
- `LINE_W`, 256, cacheline data width of all ports.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_read`  in  1  instruction-side read request.
- `inst_write`  in  1  instruction-side write request.
- `inst_address`  in  ADDR_W  instruction-side line address.
- `inst_wdata`  in  LINE_W  instruction-side write line.
- `inst_rdata`  out  LINE_W  read line; valid only while `inst_resp`=1.
- `inst_resp`  out  1  one-cycle completion pulse to the instruction side.
- `data_read`, `data_write`, `data_address`, `data_wdata`, `data_rdata`, `data_resp`: the same set of signals for the data side.
- `pmem_read`  out  1  read request to memory.
- `pmem_write`  out  1  write request to memory.
- `pmem_address`  out  ADDR_W  line address to memory.
- `pmem_wdata`  out  LINE_W  write line to memory.
- `pmem_rdata`  in  LINE_W  read line from memory.
- `pmem_resp`  in  1  memory completion pulse.

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`. Reset state is `IDLE`.
- Requester contract:
  - A requester holds read/write, address and wdata stable from assertion until the cycle its resp=1.
  - It drops the request in the following cycle.
- `IDLE` behaviour:
  - Samples the live request lines.
  - A side is pending when its read or write is asserted.
  - Only inst pending: next state `SERVE_I`.
  - Only data pending: next state `SERVE_D`.
  - Both pending: resolved by the priority rule (see Configuration).
  - None pending: stay in `IDLE`.
- `SERVE_x` behaviour:
  - `pmem_address` and `pmem_wdata` come from the granted side.
  - `pmem_write` = granted side's write.
  - `pmem_read` = granted side's read AND NOT its write. If both are asserted, write wins.
  - On `pmem_resp`=1: assert the granted side's resp in the same cycle, then go to `IDLE` on the next edge.
- The ungranted side's resp stays 0 throughout. Its request stays pending and is not dropped.
- `inst_rdata` and `data_rdata` are driven directly from `pmem_rdata` at all times. They are qualified only by the matching resp.
- In `IDLE`, all `pmem_*` outputs are 0.
- A `pmem_resp` arriving in `IDLE` is ignored: no client resp is asserted and there is no state change.

## Timing
- Reset values: `pmem_read`=0, `pmem_write`=0, `pmem_address`=0, `pmem_wdata`=0, `inst_resp`=0, `data_resp`=0.
- Request first visible in `IDLE` at cycle 0 → `pmem_read`/`pmem_write` asserted from cycle 1.
- Memory resp at cycle k ≥ 1 → client resp at cycle k, combinational pass-through with zero added latency.
- Turnaround:
  - There is exactly one `IDLE` cycle between consecutive transactions. This guarantees a requester's stale request is never re-granted.
  - Back-to-back throughput: one transaction per (memory latency + 1) cycles.
- Reset mid-transaction (`rst`=1 in `SERVE_x`):
  - State goes to `IDLE` and all outputs are 0 on the next edge.
  - Any in-flight `pmem_resp` is then ignored as above.
  - The round-robin pointer resets to favour data.
- Grant is never changed while in `SERVE_x`, even if the other side asserts a request.

## Configuration
- Macro `MEM_ARB_RR_EN`.
- Defined:
  - A 1-bit `last_grant` register (reset = inst) is updated on every transition into `SERVE_x`.
  - When both sides are pending in `IDLE`, the side not granted last wins. Under continuous contention this alternates inst/data.
- Undefined:
  - Fixed priority: data always wins when both are pending.
  - `last_grant` is not instantiated.

## Test plan
- Reset check: assert `rst` for 2 cycles with `inst_read`=1 → `pmem_read`=0, `inst_resp`=0 throughout. `pmem_read`=1 exactly one cycle after `rst` deasserts.
- Single inst read: `inst_read`=1, `inst_address`=0x0000_0060, memory responds 3 cycles after `pmem_read` with `pmem_rdata`=0xA5…A5 → `pmem_address`=0x60, `inst_resp`=1 for one cycle, `inst_rdata`=0xA5…A5.
- Data write: `data_write`=1, address 0x1000, wdata 0xDEAD…BEEF → `pmem_write`=1, `pmem_wdata` matches, `pmem_read`=0. `data_resp` is pulsed; `inst_resp` stays 0.
- Contention, fixed priority (macro undefined): both sides request in the same cycle → data served first, then after one `IDLE` cycle inst is served. Order is D,I.
- Contention, round-robin (`MEM_ARB_RR_EN`): both sides continuously re-request for 4 transactions → grant order D,I,D,I after reset.
- Reset mid-transaction: `rst` in the second cycle of `SERVE_I`, then `pmem_resp`=1 one cycle later → no `inst_resp`. FSM in `IDLE`; the re-asserted request is granted normally.
